// File: rtl/calc1_port_engine.sv
// calc1_port_engine: device end of the calc1 port; two-phase request, one-cycle response.
// Latency: response registered at edge E(1+EXEC_CYCLES) after the command edge E0, valid one cycle.
// Backpressure: none; busy is high while not IDLE and commands seen then are dropped and counted.
// Ports:
//   c_clk, reset          clock, async active-high reset
//   req_cmd_in/_data_in   command + op1, then op2 on the following cycle (bit 31 / bit 3 = LSB)
//   out_resp/out_data     0 none, 1 success, 2 error; data nonzero only on success
//   busy, drop_count      engine occupied; saturating count of ignored commands
module calc1_port_engine #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy,
  output logic [0:7]  drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  state_t      state, state_nxt;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [3:0]  cnt_q;
  logic [32:0] sum;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        cmd_seen;

  assign cmd_seen = (req_cmd_in != 4'd0);
  assign busy     = (state != IDLE);

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_seen) state_nxt = OP2;
      OP2:     state_nxt = EXEC;
      EXEC:    if (cnt_q == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result is formed from the latched operands; it is only sampled on the
  // final EXEC edge. Internal operands are stored LSB-at-0, so op2_q[4:0]
  // holds bits [27:31] of the bus.
  assign sum = {1'b0, op1_q} + {1'b0, op2_q};

  always_comb begin
    res_resp = RESP_ERR;
    res_data = 32'd0;
    case (cmd_q)
      4'd1: begin
        if (!sum[32]) begin
          res_resp = RESP_OK;
          res_data = sum[31:0];
        end
      end
      4'd2: begin
        if (op2_q <= op1_q) begin
          res_resp = RESP_OK;
          res_data = op1_q - op2_q;
        end
      end
      4'd5: begin
        res_resp = RESP_OK;
        res_data = op1_q << op2_q[4:0];
      end
      4'd6: begin
        res_resp = RESP_OK;
        res_data = op1_q >> op2_q[4:0];
      end
      default: begin
        res_resp = RESP_ERR;
        res_data = 32'd0;
      end
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= 4'd0;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      cnt_q      <= 4'd0;
      out_resp   <= 2'd0;
      out_data   <= 32'd0;
      drop_count <= 8'd0;
    end else begin
      // Response is a single-cycle pulse: cleared unless written this edge.
      out_resp <= 2'd0;
      out_data <= 32'd0;
      case (state)
        IDLE: begin
          if (cmd_seen) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
          end
        end
        OP2: begin
          op2_q <= req_data_in;
          cnt_q <= 4'(EXEC_CYCLES);
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            out_resp <= res_resp;
            out_data <= res_data;
          end
        end
        default: cnt_q <= 4'd0;
      endcase
      // Any command while occupied (including the OP2 cycle) is discarded.
      if (busy && cmd_seen && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_calc1_port_engine.sv
module tb_calc1_port_engine;

  logic        clk;
  logic        reset;
  logic [3:0]  cmd;
  logic [31:0] din;
  logic [1:0]  resp1, resp8;
  logic [31:0] data1, data8;
  logic        busy1, busy8;
  logic [7:0]  drop1, drop8;

  int tests = 0;
  int fails = 0;
  int exp_drop = 0;

  calc1_port_engine u_dut1 (
    .c_clk(clk), .reset(reset), .req_cmd_in(cmd), .req_data_in(din),
    .out_resp(resp1), .out_data(data1), .busy(busy1), .drop_count(drop1)
  );

  calc1_port_engine #(.EXEC_CYCLES(8)) u_dut8 (
    .c_clk(clk), .reset(reset), .req_cmd_in(cmd), .req_data_in(din),
    .out_resp(resp8), .out_data(data8), .busy(busy8), .drop_count(drop8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {resp, data} straight from the arithmetic rules.
  function automatic logic [33:0] ref_calc(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    longint s;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, a + b};
      end
      4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5: return {2'd1, a << (b % 32)};
      4'd6: return {2'd1, a >> (b % 32)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 16));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 16));
      default: return 32'd1 << $urandom_range(0, 31);
    endcase
  endfunction

  // Entered and left at a negedge. c2 is driven during the OP2 cycle, c3
  // during every EXEC cycle; both count as drops on the default engine.
  task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c2, input logic [3:0] c3, input bit use8);
    int n;
    logic [33:0] r;
    n = use8 ? 8 : 1;
    r = ref_calc(c, a, b);
    cmd = c;
    din = a;
    @(negedge clk);
    chk("busy_after_e0", use8 ? busy8 : busy1, 1);
    chk("resp_cleared", use8 ? resp8 : resp1, 0);
    cmd = c2;
    din = b;
    @(negedge clk);
    cmd = c3;
    din = $urandom;
    for (int i = 0; i < n; i++) begin
      chk("resp_early", use8 ? resp8 : resp1, 0);
      @(negedge clk);
    end
    chk("resp", use8 ? resp8 : resp1, 32'(r[33:32]));
    chk("data", use8 ? data8 : data1, r[31:0]);
    chk("busy_after_resp", use8 ? busy8 : busy1, 0);
    if (!use8) begin
      if (c2 != 0) exp_drop++;
      if (c3 != 0) exp_drop++;
      if (exp_drop > 255) exp_drop = 255;
      chk("drop_count", drop1, 32'(exp_drop));
    end
    cmd = 4'd0;
    din = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_drop = 0;
  endtask

  initial begin
    logic [3:0] c, c2, c3;
    reset = 1'b1;
    cmd = 4'd0;
    din = 32'd0;
    #7;
    chk("rst_resp", resp1, 0);
    chk("rst_data", data1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_drop", drop1, 0);
    chk("rst_resp8", resp8, 0);
    chk("rst_busy8", busy8, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases, chained back-to-back.
    txn(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 0, 0, 0);
    txn(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 0, 0, 0);
    txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0);
    txn(4'd2, 32'd1, 32'hF, 0, 0, 0);
    txn(4'd2, 32'd5, 32'd5, 0, 0, 0);
    txn(4'd6, 32'h8000_0000, 32'h21, 0, 0, 0);
    txn(4'd3, $urandom, $urandom, 0, 0, 0);
    txn(4'd4, $urandom, $urandom, 0, 0, 0);
    txn(4'd1, 32'd10, 32'd20, 4'd1, 0, 0);
    txn(4'd2, 32'd100, 32'd1, 0, 4'd2, 0);
    for (int k = 0; k < 32; k++) txn(4'd5, 32'd1, 32'(k), 0, 0, 0);
    for (int k = 0; k < 32; k++) txn(4'd6, $urandom, 32'(k) | ($urandom << 5), 0, 0, 0);

    // Randomized traffic with occasional illegal commands while busy.
    for (int k = 0; k < 80; k++) begin
      c  = 4'($urandom_range(1, 15));
      c2 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      c3 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      txn(c, pick_operand(), pick_operand(), c2, c3, 0);
    end
    @(negedge clk);
    chk("resp_idle_end", resp1, 0);

    // Long execute: response at E9.
    do_reset();
    txn(4'd1, 32'd7, 32'd8, 0, 0, 1);
    txn(4'd2, 32'd3, 32'd9, 0, 0, 1);
    txn(4'd5, 32'h0000_00FF, 32'd28, 0, 0, 1);

    // Reset mid-EXEC discards the pending command.
    do_reset();
    cmd = 4'd1;
    din = 32'd5;
    @(negedge clk);
    cmd = 4'd3;
    din = 32'd7;
    @(negedge clk);
    cmd = 4'd0;
    repeat (3) @(negedge clk);
    chk("mid_busy8", busy8, 1);
    chk("mid_drop8", drop8, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy8", busy8, 0);
    chk("async_drop8", drop8, 0);
    chk("async_resp8", resp8, 0);
    chk("async_data8", data8, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("no_resp_after_rst", resp8, 0);
      @(negedge clk);
    end

    // Saturation: holding a command keeps both engines dropping.
    do_reset();
    cmd = 4'd1;
    din = $urandom;
    repeat (460) @(negedge clk);
    cmd = 4'd0;
    repeat (12) @(negedge clk);
    chk("drop_sat", drop1, 255);
    chk("drop_sat8", drop8, 255);
    chk("busy_after_sat", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
